// File: rtl/disp_bcd_conv.sv
// Signed 16-bit to four-digit display converter: range check, double-dabble
// binary-to-BCD, then leading-zero blanking with a minus sign or error pattern.
module disp_bcd_conv (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [15:0] value_i,
    output logic [3:0]  dig3_o,
    output logic [3:0]  dig2_o,
    output logic [3:0]  dig1_o,
    output logic [3:0]  dig0_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLoad   = 2'd1;
    localparam logic [1:0] StShift  = 2'd2;
    localparam logic [1:0] StFormat = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] value_q, value_d;
    logic        neg_q, neg_d;
    logic        range_err_q, range_err_d;
    logic [13:0] mag_q, mag_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] disp_q, disp_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    logic signed [15:0] sval;
    logic               in_range;
    logic [13:0]        mag_load;
    logic [15:0]        bcd_adj;
    logic [15:0]        fmt;

    assign sval     = value_q;
    assign in_range = (sval >= -16'sd999) && (sval <= 16'sd9999);
    // Only the low 14 bits are negated, so -32768 cannot overflow; it is flagged anyway.
    assign mag_load = value_q[15] ? (~value_q[13:0] + 14'd1) : value_q[13:0];

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        logic found;
        found = 1'b0;
        fmt   = 16'hFFFF;
        for (int i = 3; i >= 0; i--) begin
            if (found || (bcd_q[4*i +: 4] != 4'd0) || (i == 0)) begin
                fmt[4*i +: 4] = bcd_q[4*i +: 4];
                found         = 1'b1;
            end
        end
        // Minus goes just left of the most significant shown digit.
        for (int i = 1; i < 4; i++) begin
            if (neg_q && (fmt[4*i +: 4] == 4'hF) && (fmt[4*(i-1) +: 4] <= 4'd9)) begin
                fmt[4*i +: 4] = 4'hE;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        neg_d       = neg_q;
        range_err_d = range_err_q;
        mag_d       = mag_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        disp_d      = disp_q;
        err_d       = err_q;
        done_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    value_d = value_i;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                range_err_d = !in_range;
                neg_d       = value_q[15];
                mag_d       = mag_load;
                bcd_d       = 16'h0000;
                cnt_d       = 4'd0;
                state_d     = StShift;
            end
            StShift: begin
                // Fourteen shifts, then one settling cycle before formatting.
                if (cnt_q == 4'd14) begin
                    state_d = StFormat;
                end else begin
                    bcd_d = {bcd_adj[14:0], mag_q[13]};
                    mag_d = {mag_q[12:0], 1'b0};
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StFormat: begin
                disp_d  = range_err_q ? 16'hEAAE : fmt;
                err_d   = range_err_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            value_q     <= 16'h0000;
            neg_q       <= 1'b0;
            range_err_q <= 1'b0;
            mag_q       <= 14'h0000;
            bcd_q       <= 16'h0000;
            cnt_q       <= 4'd0;
            disp_q      <= 16'hFFFF;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            neg_q       <= neg_d;
            range_err_q <= range_err_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            disp_q      <= disp_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign dig3_o = disp_q[15:12];
    assign dig2_o = disp_q[11:8];
    assign dig1_o = disp_q[7:4];
    assign dig0_o = disp_q[3:0];
    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_disp_bcd_conv.sv
// Bench for disp_bcd_conv: directed vector table, randomized values against an
// arithmetic reference model, and hand-written timing/abort sequences.
module tb_disp_bcd_conv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] value;
    logic [3:0]  dig3, dig2, dig1, dig0;
    logic        busy, done, err;
    logic [15:0] digs;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    assign digs = {dig3, dig2, dig1, dig0};

    disp_bcd_conv dut (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (start),
        .value_i (value),
        .dig3_o  (dig3),
        .dig2_o  (dig2),
        .dig1_o  (dig1),
        .dig0_o  (dig0),
        .busy_o  (busy),
        .done_o  (done),
        .err_o   (err)
    );

    typedef struct {
        int          value;
        logic [15:0] dig;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by division, blanking and sign by position.
    function automatic logic [16:0] model(input int v);
        int          m;
        int          p;
        int          dg[4];
        logic [15:0] codes;
        if (v < -999 || v > 9999) return {1'b1, 16'hEAAE};
        m = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 4; i++) begin
            dg[i] = (m / (10 ** i)) % 10;
            if (dg[i] != 0) p = i;
        end
        for (int i = 0; i < 4; i++) begin
            if (i <= p)                    codes[4*i +: 4] = 4'(dg[i]);
            else if (v < 0 && i == p + 1)  codes[4*i +: 4] = 4'hE;
            else                           codes[4*i +: 4] = 4'hF;
        end
        return {1'b0, codes};
    endfunction

    task automatic run_conv(input int v, input logic [15:0] exp_dig, input logic exp_err,
                            input string name);
        int          lat;
        int          busy_cnt;
        bit          hold_ok;
        logic [15:0] prev_dig;
        logic        prev_err;
        @(negedge clk);
        value = 16'(v);
        start = 1'b1;
        prev_dig = digs;
        prev_err = err;
        @(posedge clk);
        #1;
        start    = 1'b0;
        value    = 16'($urandom);
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        hold_ok  = 1'b1;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cnt++;
            if (!done && (digs !== prev_dig || err !== prev_err)) hold_ok = 1'b0;
        end
        check({name, " latency"}, lat, 17);
        check({name, " digits"}, digs, exp_dig);
        check({name, " err"}, err, exp_err);
        check({name, " busy cycles"}, busy_cnt, 17);
        check({name, " hold"}, hold_ok, 1'b1);
        @(posedge clk);
        #1;
        check({name, " done width"}, done, 1'b0);
    endtask

    initial begin
        int          n_done;
        int          done_at;
        int          d_times[$];
        int          rv;
        logic [16:0] m;

        reset = 1'b1;
        start = 1'b0;
        value = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset err", err, 1'b0);
        check("reset digits", digs, 16'hFFFF);
        @(negedge clk);
        reset = 1'b0;

        vecs.push_back('{1234,   16'h1234, 1'b0});
        vecs.push_back('{-42,    16'hFE42, 1'b0});
        vecs.push_back('{-999,   16'hE999, 1'b0});
        vecs.push_back('{0,      16'hFFF0, 1'b0});
        vecs.push_back('{9999,   16'h9999, 1'b0});
        vecs.push_back('{10000,  16'hEAAE, 1'b1});
        vecs.push_back('{7,      16'hFFF7, 1'b0});
        vecs.push_back('{-1000,  16'hEAAE, 1'b1});
        vecs.push_back('{-1,     16'hFFE1, 1'b0});
        vecs.push_back('{-32768, 16'hEAAE, 1'b1});
        vecs.push_back('{7,      16'hFFF7, 1'b0});
        vecs.push_back('{100,    16'hF100, 1'b0});
        vecs.push_back('{-100,   16'hE100, 1'b0});
        vecs.push_back('{32767,  16'hEAAE, 1'b1});
        vecs.push_back('{-9,     16'hFFE9, 1'b0});
        for (int i = 0; i < vecs.size(); i++) begin
            run_conv(vecs[i].value, vecs[i].dig, vecs[i].err, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) != 0) rv = int'($urandom_range(0, 11000)) - 1000;
            else                           rv = int'($signed(16'($urandom)));
            m = model(rv);
            run_conv(rv, m[15:0], m[16], $sformatf("rand%0d(%0d)", i, rv));
        end

        // Second start during a conversion must be ignored.
        @(negedge clk);
        value = 16'd555;
        start = 1'b1;
        @(posedge clk);
        #1;
        n_done  = 0;
        done_at = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 5) begin
                start = 1'b1;
                value = 16'(-7);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                done_at = c;
            end
        end
        check("ignore start done count", n_done, 1);
        check("ignore start latency", done_at, 17);
        check("ignore start digits", digs, 16'hF555);

        // Reset mid-conversion aborts without a done.
        @(negedge clk);
        value = 16'd4321;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 8) reset = 1'b1;
            @(posedge clk);
            #1;
        end
        check("abort busy", busy, 1'b0);
        check("abort digits", digs, 16'hFFFF);
        check("abort err", err, 1'b0);
        @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("abort no done", n_done, 0);
        run_conv(4321, 16'h4321, 1'b0, "after abort");

        // Start held high: one done every 18 cycles.
        @(negedge clk);
        value = 16'd321;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (done) d_times.push_back(c);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("b2b done count", d_times.size(), 3);
        if (d_times.size() >= 3) begin
            check("b2b first", d_times[0], 17);
            check("b2b gap1", d_times[1] - d_times[0], 18);
            check("b2b gap2", d_times[2] - d_times[1], 18);
        end
        check("b2b digits", digs, 16'hF321);
        check("b2b idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
